div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit_if.sv | 27 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: instruction control codes
// used by hazard and alu, the divider FSM state encoding, iteration limits
// and a magnitude helper.
package div_unit_pkg;

    // Control codes for the two divide instructions (funct field values).
    localparam logic [5:0] DIV_CONTROL  = 6'b011010;
    localparam logic [5:0] DIVU_CONTROL = 6'b011011;

    // Divider FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Counter value during the 32nd (final) restoring iteration.
    localparam logic [5:0] LAST_ITER = 6'd31;

    // Absolute value of a 32-bit operand; signed mode only. The magnitude of
    // 0x80000000 is 0x80000000, which is correct as an unsigned number.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the E-stage and the divider.
//
// Handshake: the requester holds start high (with signed_div and operands
// stable) while the divider is idle; the divider takes the request on the
// first rising edge it sees start in IDLE. ready is a one-cycle pulse marking
// result valid; result then holds until the next completion. annul cancels
// any request or operation in flight and suppresses ready.
interface div_unit_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, busy
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes: shift the
// next dividend bit into the partial remainder, subtract the divisor if it
// fits, and shift the resulting quotient bit in.
module div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        take;

    // Shift/compare/subtract; the partial remainder stays below the divisor,
    // so the difference always fits in 32 bits when the subtraction is taken.
    always_comb begin
        shifted = {rem_in, quo_in[31]};
        take    = (shifted >= {1'b0, divisor});
        diff    = shifted[31:0] - divisor;
        rem_out = take ? diff : shifted[31:0];
        quo_out = {quo_in[30:0], take};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: IDLE -> BUSY (32 restoring iterations) ->
// DONE, with a one-cycle shortcut to DONE for a zero divisor. Signed operands
// are divided as magnitudes and fixed up on completion.
// Optional feature: DIV_EARLY_OUT_EN adds a shortcut for |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus,
    output div_state_e dbg_state
);

    div_state_e  state, state_next;
    logic [5:0]  count;
    logic [31:0] part_rem;
    logic [31:0] quo_sh;
    logic [31:0] dvs_mag;
    logic        neg_quo;
    logic        neg_rem;
    logic [63:0] result_q;

    logic        accept;
    logic        div_zero;
    logic        early;
    logic        short_path;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] short_result;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] fix_rem;
    logic [31:0] fix_quo;

    assign a_mag    = mag32(bus.opdata1, bus.signed_div);
    assign b_mag    = mag32(bus.opdata2, bus.signed_div);
    assign div_zero = (bus.opdata2 == 32'd0);

`ifdef DIV_EARLY_OUT_EN
    // Quotient is zero whenever the dividend magnitude is below the divisor's.
    assign early = !div_zero && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign short_path = div_zero || early;

    // Both shortcuts return the raw dividend as remainder; only the quotient differs.
    assign short_result = {bus.opdata1, (div_zero ? 32'hFFFF_FFFF : 32'h0000_0000)};

    div_step u_step (
        .rem_in  (part_rem),
        .quo_in  (quo_sh),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign fix_quo = neg_quo ? (~step_quo + 32'd1) : step_quo;
    assign fix_rem = neg_rem ? (~step_rem + 32'd1) : step_rem;

    // Next-state logic; annul overrides everything, including a pending start.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = short_path ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (count == LAST_ITER) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (bus.annul) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= 6'd0;
            part_rem <= 32'd0;
            quo_sh   <= 32'd0;
            dvs_mag  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= 64'd0;
        end else if (accept) begin
            count    <= 6'd0;
            part_rem <= 32'd0;
            quo_sh   <= a_mag;
            dvs_mag  <= b_mag;
            neg_quo  <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
            neg_rem  <= bus.signed_div && bus.opdata1[31];
            if (short_path) begin
                result_q <= short_result;
            end
        end else if (state == ST_BUSY && !bus.annul) begin
            count    <= count + 6'd1;
            part_rem <= step_rem;
            quo_sh   <= step_quo;
            if (count == LAST_ITER) begin
                result_q <= {fix_rem, fix_quo};
            end
        end else begin
            count <= 6'd0;
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = (state == ST_DONE) && !bus.annul;
    assign bus.busy   = (state == ST_BUSY);
    assign dbg_state  = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic       clk;
    logic       resetn;
    div_state_e dbg_state;

    div_unit_if bus ();

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 64'd0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint mag(input logic [31:0] v, input logic sgn);
        longint x;
        x = sgn ? longint'($signed(v)) : longint'(v);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        x = sgn ? longint'($signed(a)) : longint'(a);
        y = sgn ? longint'($signed(b)) : longint'(b);
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(a, sgn) < mag(b, sgn)) return 1;
`else
        if (mag(a, sgn) < 0) return 0;
`endif
        return 33;
    endfunction

    // ---------------- driver ----------------
    // Issue one operation from a negedge with the unit idle; returns at a negedge, idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp_res, input string tag);
        int lat;
        int exp_lat;
        logic [63:0] e;
        exp_q.push_back(exp_res);
        exp_lat = exp_latency(a, b, sgn);
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.opdata1 = $urandom;
            bus.opdata2 = $urandom;
            lat++;
            if (lat == 1) chk({tag, "_busy"}, 64'(bus.busy), 64'(exp_lat > 1));
        end while (!bus.ready && lat < 40);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        e = exp_q.pop_front();
        chk({tag, "_res"}, bus.result, e);
        last_exp = e;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.ready), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b;
        logic        s;
        int          pulses;

        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd0;
        bus.opdata2    = 32'd0;
        bus.annul      = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        chk("rst_result", bus.result, 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Directed cases.
        do_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, "u100_7");
        do_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, "s_ovf");
        do_op(32'd5, 32'd0, 1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, "u5_0");
        do_op(32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "s_m7_0");
        do_op(32'd3, 32'd10, 1'b0, {32'h0000_0003, 32'h0000_0000}, "u3_10");
        do_op(32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'h0000_0000}, "s_m3_10");

        // Annul in the 10th BUSY cycle, then rerun.
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd9; bus.opdata2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        chk("annul_busy", 64'(bus.busy), 64'd0);
        chk("annul_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("annul_result", bus.result, last_exp);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        chk("annul_noready", 64'(pulses), 64'd0);
        do_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, "u9_3");

        // annul wins over start in the same cycle.
        bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd9; bus.opdata2 = 32'd3;
        @(negedge clk);
        chk("annul_start", 64'(dbg_state), 64'(ST_IDLE));
        bus.start = 1'b0; bus.annul = 1'b0;
        @(negedge clk);

        // start held across two operations; operands changed mid-BUSY.
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
        @(posedge clk);
        pulses = 0;
        for (int n = 1; n <= 67; n++) begin
            @(negedge clk);
            if (n == 5) begin
                bus.opdata1 = 32'd50;
                bus.opdata2 = 32'd5;
            end
            if (n == 34) chk("b2b_idle_gap", 64'(dbg_state), 64'(ST_IDLE));
            if (bus.ready) begin
                pulses++;
                chk("b2b_at", 64'(n), (pulses == 1) ? 64'd33 : 64'd67);
                chk("b2b_res", bus.result, (pulses == 1) ? {32'd2, 32'd14} : {32'd0, 32'd10});
            end
            if (n == 67) bus.start = 1'b0;
        end
        chk("b2b_pulses", 64'(pulses), 64'd2);
        @(negedge clk);
        chk("b2b_after", 64'(bus.ready), 64'd0);
        last_exp = {32'd0, 32'd10};

        // Asynchronous reset in the middle of BUSY.
        bus.start = 1'b1; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_result", bus.result, 64'd0);
        chk("arst_ready", 64'(bus.ready), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        resetn = 1'b1;
        do_op(32'd77, 32'd7, 1'b0, {32'd0, 32'd11}, "after_rst");

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 8);
            endcase
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, ref_div(a, b, s), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
